// File: rtl/irq_sched_ctrl.sv
// Sequential interrupt scheduler: pending latch, per-group enable masks, fixed-priority
// arbitration, valid/ready presentation and EOI tracking. Optional watchdog: IRQ_SCHED_TIMEOUT_EN.
module irq_sched_ctrl #(
    parameter int NCH         = 9,
    parameter int NGRP        = 3,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NGRP*NCH-1:0]  req_i,
    input  logic                 cfg_we_i,
    input  logic [1:0]           cfg_grp_i,
    input  logic [NCH-1:0]       cfg_mask_i,
    output logic                 irq_valid_o,
    input  logic                 irq_ready_i,
    output logic [1:0]           irq_grp_o,
    output logic [3:0]           irq_ch_o,
    input  logic                 eoi_i,
    output logic                 busy_o,
    output logic [NGRP*NCH-1:0]  pend_o,
    output logic                 timeout_o
);

    localparam int NBIT = NGRP * NCH;

    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 2");
    end

    typedef enum logic [1:0] {IDLE, ARB, PRESENT, SERVICE} state_t;

    state_t          state_q, state_d;
    logic [NBIT-1:0] pend_q, elig, clr_vec;
    logic [NCH-1:0]  en_q [NGRP];
    logic [1:0]      grp_q, win_grp;
    logic [3:0]      ch_q, win_ch;
    logic            win_found, handshake, timeout_hit;

    always_comb begin
        elig = '0;
        for (int g = 0; g < NGRP; g++) begin
            elig[g*NCH +: NCH] = pend_q[g*NCH +: NCH] & en_q[g];
        end
    end

    // Group-major bit order means the first set bit is the lowest group, then lowest channel.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        win_found = 1'b0;
        win_grp   = '0;
        win_ch    = '0;
        for (int g = 0; g < NGRP; g++) begin
            for (int c = 0; c < NCH; c++) begin
                if (!win_found && elig[g*NCH + c]) begin
                    win_found = 1'b1;
                    win_grp   = 2'(g);
                    win_ch    = 4'(c);
                end
            end
        end
    end

    assign handshake = (state_q == PRESENT) && irq_ready_i;
    assign clr_vec   = handshake ? (NBIT'(1) << (int'(grp_q) * NCH + int'(ch_q))) : '0;

`ifdef IRQ_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC);
    logic [CW-1:0] svc_cnt_q;

    // Held at zero outside SERVICE, so it starts from zero on every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    svc_cnt_q <= '0;
        else if (state_q != SERVICE)   svc_cnt_q <= '0;
        else                           svc_cnt_q <= svc_cnt_q + 1'b1;
    end

    assign timeout_hit = (state_q == SERVICE) && (svc_cnt_q == CW'(TIMEOUT_CYC - 1)) && !eoi_i;
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (|elig)       state_d = ARB;
            ARB:     state_d = win_found ? PRESENT : IDLE;
            PRESENT: if (irq_ready_i) state_d = SERVICE;
            SERVICE: if (eoi_i || timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        irq_valid_o = (state_q == PRESENT);
        busy_o      = (state_q == SERVICE);
        timeout_o   = timeout_hit;
    end

    // A re-request in the grant cycle wins over the clear, so it is OR-ed in last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            grp_q  <= '0;
            ch_q   <= '0;
            for (int g = 0; g < NGRP; g++) en_q[g] <= '0;
        end else begin
            pend_q <= (pend_q & ~clr_vec) | req_i;
            if (cfg_we_i && (int'(cfg_grp_i) < NGRP)) en_q[cfg_grp_i] <= cfg_mask_i;
            if (state_q == ARB && win_found) begin
                grp_q <= win_grp;
                ch_q  <= win_ch;
            end
        end
    end

    assign irq_grp_o = grp_q;
    assign irq_ch_o  = ch_q;
    assign pend_o    = pend_q;

endmodule

// File: tb/tb_irq_sched_ctrl.sv
// Self-checking bench for irq_sched_ctrl: per-cycle comparison against a behavioural model
// plus directed scenarios with literal expectations.
module tb_irq_sched_ctrl;

    localparam int NCH    = 9;
    localparam int NGRP   = 3;
    localparam int NB     = NCH * NGRP;
    localparam int TO_CYC = 16;
`ifdef IRQ_SCHED_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0, rst_n = 1'b0;
    logic [NB-1:0] req = '0;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_grp = '0;
    logic [NCH-1:0] cfg_mask = '0;
    logic          ready = 1'b0, eoi = 1'b0;
    logic          irq_valid, busy, timeout;
    logic [1:0]    irq_grp;
    logic [3:0]    irq_ch;
    logic [NB-1:0] pend;

    int n_checks = 0;
    int n_fail   = 0;

    irq_sched_ctrl #(.NCH(NCH), .NGRP(NGRP), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .cfg_we_i(cfg_we), .cfg_grp_i(cfg_grp),
        .cfg_mask_i(cfg_mask), .irq_valid_o(irq_valid), .irq_ready_i(ready),
        .irq_grp_o(irq_grp), .irq_ch_o(irq_ch), .eoi_i(eoi), .busy_o(busy),
        .pend_o(pend), .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: stage 0 idle, 1 arbitrating, 2 presenting, 3 in service.
    bit [NB-1:0]  m_pend;
    bit [NCH-1:0] m_en [NGRP];
    int m_stage, m_win, m_svc;

    function automatic int first_elig();
        for (int i = 0; i < NB; i++)
            if (m_pend[i] && m_en[i / NCH][i % NCH]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_pend = '0;
        for (int g = 0; g < NGRP; g++) m_en[g] = '0;
        m_stage = 0; m_win = 0; m_svc = 0;
    endtask

    task automatic model_step();
        int w;
        int clr;
        w   = first_elig();
        clr = (m_stage == 2 && ready) ? m_win : -1;
        case (m_stage)
            0: if (w >= 0) m_stage = 1;
            1: if (w >= 0) begin m_win = w; m_stage = 2; end else m_stage = 0;
            2: if (ready) begin m_stage = 3; m_svc = 0; end
            default: if (eoi || (TO_EN && m_svc == TO_CYC - 1)) m_stage = 0; else m_svc++;
        endcase
        if (clr >= 0) m_pend[clr] = 1'b0;
        m_pend |= req;
        if (cfg_we && int'(cfg_grp) < NGRP) m_en[cfg_grp] = cfg_mask;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
            #1;
            check("valid",   irq_valid, 32'(m_stage == 2));
            check("grp",     irq_grp,   32'(m_win / NCH));
            check("ch",      irq_ch,    32'(m_win % NCH));
            check("busy",    busy,      32'(m_stage == 3));
            check("pend",    pend,      32'(m_pend));
            check("timeout", timeout,   32'(TO_EN && m_stage == 3 && m_svc == TO_CYC - 1 && !eoi));
        end
    end

    // Inputs change 2 time units after the rising edge; outputs are stable by then.
    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; cfg_we = 1'b0; ready = 1'b0; eoi = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
    endtask

    task automatic write_mask(input logic [1:0] g, input logic [NCH-1:0] m);
        cfg_we = 1'b1; cfg_grp = g; cfg_mask = m;
        cyc(1);
        cfg_we = 1'b0;
    endtask

    task automatic pulse_req(input int idx);
        req[idx] = 1'b1;
        cyc(1);
        req[idx] = 1'b0;
    endtask

    task automatic wait_valid(input int max);
        for (int i = 0; i < max; i++) begin
            if (irq_valid) break;
            cyc(1);
        end
        check("valid_within_bound", irq_valid, 1);
    endtask

    task automatic eoi_pulse();
        eoi = 1'b1;
        cyc(1);
        eoi = 1'b0;
    endtask

    task automatic accept_and_eoi();
        ready = 1'b1; cyc(1); ready = 1'b0;
        eoi_pulse();
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    int eg[3] = '{0, 0, 2};
    int ec[3] = '{3, 8, 0};

    initial begin
        do_reset();
        check("rst_valid", irq_valid, 0);
        check("rst_pend", pend, 0);

        // Latency: request in cycle t, presented in cycle t+3.
        write_mask(0, 9'h1FF); write_mask(1, 9'h1FF); write_mask(2, 9'h1FF);
        pulse_req(14);
        check("lat_t1_valid", irq_valid, 0);
        cyc(1);
        check("lat_t2_valid", irq_valid, 0);
        cyc(1);
        check("lat_t3_valid", irq_valid, 1);
        check("lat_t3_grp", irq_grp, 1);
        check("lat_t3_ch", irq_ch, 5);
        ready = 1'b1; cyc(1); ready = 1'b0;
        check("hs_pend14", pend[14], 0);
        check("hs_busy", busy, 1);
        eoi_pulse();

        // Three simultaneous requests are served in priority order.
        ready = 1'b1;
        req[18] = 1'b1; req[8] = 1'b1; req[3] = 1'b1;
        cyc(1);
        req = '0;
        for (int k = 0; k < 3; k++) begin
            wait_valid(10);
            check($sformatf("order%0d_grp", k), irq_grp, eg[k]);
            check($sformatf("order%0d_ch", k), irq_ch, ec[k]);
            cyc(2);
            eoi_pulse();
        end
        ready = 1'b0;

        // Masked request stays pending; an ignored out-of-range mask write does not enable it.
        do_reset();
        write_mask(3, 9'h1FF);
        pulse_req(11);
        for (int i = 0; i < 20; i++) begin
            check("masked_no_valid", irq_valid, 0);
            cyc(1);
        end
        check("masked_pend11", pend[11], 1);
        write_mask(1, 9'h004);
        wait_valid(3);
        check("unmask_grp", irq_grp, 1);
        check("unmask_ch", irq_ch, 2);
        accept_and_eoi();

        // A committed grant holds while a higher-priority request arrives.
        write_mask(0, 9'h1FF);
        pulse_req(1);
        wait_valid(5);
        pulse_req(0);
        for (int i = 0; i < 10; i++) begin
            check("hold_grp", irq_grp, 0);
            check("hold_ch", irq_ch, 1);
            check("hold_valid", irq_valid, 1);
            cyc(1);
        end
        accept_and_eoi();
        wait_valid(5);
        check("after_hold_grp", irq_grp, 0);
        check("after_hold_ch", irq_ch, 0);
        accept_and_eoi();

        // Re-request in the handshake cycle: set beats clear, same channel granted again.
        pulse_req(4);
        wait_valid(5);
        check("rereq_ch", irq_ch, 4);
        ready = 1'b1; req[4] = 1'b1;
        cyc(1);
        ready = 1'b0; req[4] = 1'b0;
        check("rereq_pend4", pend[4], 1);
        check("rereq_busy", busy, 1);
        eoi_pulse();
        wait_valid(5);
        check("rereq_again_grp", irq_grp, 0);
        check("rereq_again_ch", irq_ch, 4);
        accept_and_eoi();

        // Withheld EOI: watchdog fires in the 16th service cycle when compiled in.
        write_mask(2, 9'h1FF);
        pulse_req(22);
        wait_valid(5);
        ready = 1'b1; cyc(1); ready = 1'b0;
        cyc(15);
        check("wd_busy_16th", busy, 1);
        check("wd_timeout_16th", timeout, 32'(TO_EN));
        cyc(1);
        check("wd_timeout_after", timeout, 0);
        check("wd_busy_after", busy, 32'(!TO_EN));
        if (!TO_EN) eoi_pulse();

        // Asynchronous reset in SERVICE clears everything without a clock edge.
        pulse_req(22);
        wait_valid(5);
        ready = 1'b1; cyc(1); ready = 1'b0;
        cyc(2);
        check("pre_rst_busy", busy, 1);
        #5;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_valid", irq_valid, 0);
        check("arst_grp", irq_grp, 0);
        check("arst_ch", irq_ch, 0);
        check("arst_pend", pend, 0);
        check("arst_timeout", timeout, 0);
        cyc(1);
        rst_n = 1'b1;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
